exu_div_mbpta_issue: RTL and testbench

- Initiator side of the constant-latency (MBPTA) divider interface.
- Accepts one divide request at a time from decode and launches it to the divider as a single-cycle packet with operands.
- Tracks the divide until finish, then presents the result as a writeback packet with a valid/ready handshake.
- Handles pipeline flush by discarding the result without perturbing divider timing; optionally checks that every divide completes in exactly LATENCY cycles.

---
 rtl/exu_div_mbpta_issue.sv | 139 +++++++++++++
 tb/tb_exu_div_mbpta_issue.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/exu_div_mbpta_issue.sv
// Issue/writeback side of the constant-latency (MBPTA) divider: launch, track, flush-drain, writeback.
// Optional latency checker enabled by defining DIV_MBPTA_LAT_CHECK_EN.
module exu_div_mbpta_issue #(
  parameter int LATENCY = 34,
  parameter int CNT_W   = 6
) (
  input  logic        clk,
  input  logic        rst_l,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_unsign,
  input  logic        req_rem,
  input  logic [4:0]  req_rd,
  input  logic [31:0] req_dividend,
  input  logic [31:0] req_divisor,
  output logic        div_valid,
  output logic        div_unsign,
  output logic        div_rem,
  output logic [31:0] div_dividend,
  output logic [31:0] div_divisor,
  input  logic        div_stall,
  input  logic        div_finish,
  input  logic [31:0] div_out,
  input  logic        flush_lower,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        lat_err
);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT, WB, DRAIN} state_t;

  localparam logic [CNT_W-1:0] LAT_C = CNT_W'(LATENCY);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             accept;
  logic             capture;

  assign accept  = (state == IDLE) && req_valid;
  assign capture = (state == WAIT) && div_finish && !flush_lower;

  // Gated by reset so every output reads 0 while rst_l is held low.
  assign req_ready = (state == IDLE) && rst_l;
  assign div_valid = (state == LAUNCH);
  assign wb_valid  = (state == WB);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = flush_lower ? DRAIN : WAIT;
      WAIT: begin
        if (flush_lower)     state_nxt = div_finish ? IDLE : DRAIN;
        else if (div_finish) state_nxt = WB;
      end
      WB:      if (wb_ready) state_nxt = IDLE;
      DRAIN:   if (div_finish) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      div_unsign   <= 1'b0;
      div_rem      <= 1'b0;
      wb_rd        <= 5'd0;
      div_dividend <= 32'd0;
      div_divisor  <= 32'd0;
    end else if (accept) begin
      div_unsign   <= req_unsign;
      div_rem      <= req_rem;
      wb_rd        <= req_rd;
      div_dividend <= req_dividend;
      div_divisor  <= req_divisor;
    end
  end

  // Counter reads 1 in the first cycle after launch, so it equals LATENCY on a well-timed finish.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      cnt <= '0;
    end else if (state == LAUNCH) begin
      cnt <= CNT_W'(1);
    end else if ((state == WAIT) || (state == DRAIN)) begin
      if (cnt != '1) cnt <= cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wb_data <= 32'd0;
    end else if (capture) begin
      wb_data <= div_out;
    end
  end

`ifdef DIV_MBPTA_LAT_CHECK_EN
  logic lat_hit;
  logic tracking;

  assign tracking = (state == WAIT) || (state == DRAIN);

  always_comb begin
    lat_hit = 1'b0;
    if (div_finish) begin
      lat_hit = tracking ? (cnt != LAT_C) : 1'b1;
    end else if (tracking && (cnt > LAT_C)) begin
      lat_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      lat_err <= 1'b0;
    end else if (lat_hit) begin
      lat_err <= 1'b1;
    end
  end

  logic unused_sig;
  assign unused_sig = div_stall;
`else
  assign lat_err = 1'b0;

  logic unused_sig;
  assign unused_sig = div_stall ^ (^cnt) ^ (^LAT_C);
`endif

endmodule

// File: tb/tb_exu_div_mbpta_issue.sv
// Directed bench for exu_div_mbpta_issue with a fixed-latency divider stand-in.
module tb_exu_div_mbpta_issue;

`ifdef DIV_MBPTA_LAT_CHECK_EN
  localparam logic LAT_EN = 1'b1;
`else
  localparam logic LAT_EN = 1'b0;
`endif

  logic        clk;
  logic        rst_l;
  logic        req_valid;
  logic        req_ready;
  logic        req_unsign;
  logic        req_rem;
  logic [4:0]  req_rd;
  logic [31:0] req_dividend;
  logic [31:0] req_divisor;
  logic        div_valid;
  logic        div_unsign;
  logic        div_rem;
  logic [31:0] div_dividend;
  logic [31:0] div_divisor;
  logic        div_stall;
  logic        div_finish;
  logic [31:0] div_out;
  logic        flush_lower;
  logic        wb_valid;
  logic        wb_ready;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        lat_err;

  int          pass_cnt = 0;
  int          fail_cnt = 0;
  int          total_cnt = 0;

  // Divider stand-in: finishes fin_at cycles after the launch cycle, returning div_result.
  int          fin_at = 34;
  logic [31:0] div_result = 32'd0;
  logic        busy = 1'b0;
  int          off = 0;

  exu_div_mbpta_issue #(.LATENCY(34), .CNT_W(6)) dut (
    .clk(clk), .rst_l(rst_l),
    .req_valid(req_valid), .req_ready(req_ready), .req_unsign(req_unsign),
    .req_rem(req_rem), .req_rd(req_rd), .req_dividend(req_dividend),
    .req_divisor(req_divisor),
    .div_valid(div_valid), .div_unsign(div_unsign), .div_rem(div_rem),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_stall(div_stall), .div_finish(div_finish), .div_out(div_out),
    .flush_lower(flush_lower),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .lat_err(lat_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    div_finish = 1'b0;
    div_stall  = 1'b0;
    div_out    = 32'd0;
    forever begin
      @(negedge clk);
      if (!rst_l) begin
        busy = 1'b0;
        div_finish = 1'b0;
        div_stall = 1'b0;
      end else begin
        if (div_valid) begin
          busy = 1'b1;
          off = 0;
        end else if (busy) begin
          off++;
        end
        div_finish = busy && (off == fin_at);
        div_stall  = busy && !div_finish;
        if (div_finish) begin
          div_out = div_result;
          busy = 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input string tag, input logic u, input logic r, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input logic [31:0] res);
    div_result = res;
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_unsign = u; req_rem = r; req_rd = rd;
    req_dividend = a; req_divisor = b;
    tick();
    req_valid = 1'b0;
    check({tag, "_div_valid"}, {31'd0, div_valid}, 32'd1);
    check({tag, "_dividend"}, div_dividend, a);
    check({tag, "_divisor"}, div_divisor, b);
    check({tag, "_flags"}, {30'd0, div_unsign, div_rem}, {30'd0, u, r});
    check({tag, "_busy"}, {31'd0, req_ready}, 32'd0);
  endtask

  task automatic wait_wb(output int n);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (i == 1) check("pulse_once", {31'd0, div_valid}, 32'd0);
      if (wb_valid) begin
        n = i;
        break;
      end
    end
  endtask

  initial begin
    int n;
    logic saw_wb;
    rst_l = 1'b0; req_valid = 1'b0; req_unsign = 1'b0; req_rem = 1'b0; req_rd = 5'd0;
    req_dividend = 32'd0; req_divisor = 32'd0; flush_lower = 1'b0; wb_ready = 1'b1;
    tick(); tick();
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    check("rst_valids", {29'd0, div_valid, wb_valid, lat_err}, 32'd0);
    check("rst_wb_data", wb_data, 32'd0);
    rst_l = 1'b1;
    tick();
    check("idle_ready", {31'd0, req_ready}, 32'd1);

    // Unsigned 100/7 quotient
    launch("u100_7", 1'b1, 1'b0, 5'd5, 32'd100, 32'd7, 32'd14);
    wait_wb(n);
    check("u100_7_lat", n, 35);
    check("u100_7_rd", {27'd0, wb_rd}, 32'd5);
    check("u100_7_data", wb_data, 32'd14);
    check("u100_7_laterr", {31'd0, lat_err}, 32'd0);
    tick();
    check("u100_7_done", {30'd0, wb_valid, req_ready}, 32'd1);

    // Signed -100/7 remainder then quotient
    launch("s_rem", 1'b0, 1'b1, 5'd9, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFFE);
    wait_wb(n);
    check("s_rem_lat", n, 35);
    check("s_rem_data", wb_data, 32'hFFFFFFFE);
    check("s_rem_rd", {27'd0, wb_rd}, 32'd9);
    tick();
    launch("s_quo", 1'b0, 1'b0, 5'd10, 32'hFFFFFF9C, 32'd7, 32'hFFFFFFF2);
    wait_wb(n);
    check("s_quo_lat", n, 35);
    check("s_quo_data", wb_data, 32'hFFFFFFF2);
    tick();

    // Flush in WAIT at counter 10
    launch("flush", 1'b1, 1'b0, 5'd3, 32'd81, 32'd9, 32'd9);
    repeat (10) tick();
    flush_lower = 1'b1;
    tick();
    flush_lower = 1'b0;
    check("flush_ready0", {31'd0, req_ready}, 32'd0);
    saw_wb = 1'b0;
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (wb_valid) saw_wb = 1'b1;
      if (req_ready) begin
        n = i;
        break;
      end
    end
    check("flush_no_wb", {31'd0, saw_wb}, 32'd0);
    check("flush_ready_at", n, 24);

    // Writeback back-pressure on 50/5
    wb_ready = 1'b0;
    launch("bp", 1'b1, 1'b0, 5'd7, 32'd50, 32'd5, 32'd10);
    wait_wb(n);
    check("bp_lat", n, 35);
    for (int k = 0; k < 4; k++) begin
      if (k == 3) wb_ready = 1'b1;
      check("bp_hold_valid", {31'd0, wb_valid}, 32'd1);
      check("bp_hold_data", wb_data, 32'd10);
      check("bp_hold_rd", {27'd0, wb_rd}, 32'd7);
      check("bp_hold_ready", {31'd0, req_ready}, 32'd0);
      tick();
    end
    check("bp_done", {30'd0, wb_valid, req_ready}, 32'd1);

    // Finish and flush in the same cycle
    launch("ff", 1'b1, 1'b0, 5'd2, 32'd20, 32'd4, 32'd5);
    n = -1;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (div_finish) begin
        n = i;
        break;
      end
    end
    check("ff_finish_at", n, 34);
    flush_lower = 1'b1;
    tick();
    flush_lower = 1'b0;
    check("ff_idle", {30'd0, wb_valid, req_ready}, 32'd1);
    check("ff_data_kept", wb_data, 32'd10);

    // Early finish at counter 20
    fin_at = 20;
    launch("early", 1'b1, 1'b0, 5'd4, 32'd9, 32'd3, 32'd3);
    wait_wb(n);
    check("early_lat", n, 21);
    check("early_laterr", {31'd0, lat_err}, {31'd0, LAT_EN});
    tick();
    fin_at = 34;
    launch("after", 1'b1, 1'b1, 5'd6, 32'd17, 32'd5, 32'd2);
    wait_wb(n);
    check("after_lat", n, 35);
    check("after_data", wb_data, 32'd2);
    check("after_sticky", {31'd0, lat_err}, {31'd0, LAT_EN});
    tick();

    // Reset in the middle of a divide
    launch("mid", 1'b1, 1'b0, 5'd8, 32'd99, 32'd9, 32'd11);
    repeat (5) tick();
    rst_l = 1'b0;
    #1;
    check("arst_ready", {31'd0, req_ready}, 32'd0);
    check("arst_flags", {27'd0, div_valid, wb_valid, lat_err, div_unsign, div_rem}, 32'd0);
    check("arst_dividend", div_dividend, 32'd0);
    check("arst_divisor", div_divisor, 32'd0);
    check("arst_wb", {wb_data[26:0], wb_rd}, 32'd0);
    check("arst_wb_data", wb_data, 32'd0);
    tick();
    rst_l = 1'b1;
    tick();
    check("post_rst_ready", {31'd0, req_ready}, 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
